pipelined_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor. It generalises the team's 4-bit gate-level ripple adder to WIDTH bits, split into STAGES carry-registered slices, with a valid/ready handshake on both sides. It sits in the datapath wherever a wide add must close timing at the system clock, for example in accumulators, address generators and the ALU back end.

---
 rtl/pipelined_adder.sv | 126 ++++++++++++
 tb/tb_pipelined_adder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES carry-registered slices.
// Optional PIPE_OVF_EN adds a signed-overflow output aligned with sum.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = WIDTH / STAGES;

    // Handshake: a transfer happens on a side when its valid and ready are both
    // high at the rising edge. The whole pipe advances together whenever the
    // output register is empty or being consumed, so in_ready mirrors advance.
    logic             advance;
    logic             last_valid;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign b_eff    = sub ? ~b : b;
    assign cin_eff  = sub | c_in;
    assign advance  = out_ready | ~last_valid;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * CHUNK;  // operand bits still to be added
        localparam int SW = (k + 1) * CHUNK;    // sum bits completed after this slice

        logic [IW-1:0]  op_a;
        logic [IW-1:0]  op_b;
        logic           cin;
        logic           vin;
        logic [CHUNK:0] slice;
        logic [SW-1:0]  sum_d;
        logic [SW-1:0]  sum_q;
        logic           valid_q;
        logic           carry_q;

        if (k == 0) begin : g_head
            assign op_a  = a;
            assign op_b  = b_eff;
            assign cin   = cin_eff;
            assign vin   = in_valid;
            assign sum_d = slice[CHUNK-1:0];
        end else begin : g_body
            assign op_a  = g_stage[k-1].g_ops.a_q;
            assign op_b  = g_stage[k-1].g_ops.b_q;
            assign cin   = g_stage[k-1].carry_q;
            assign vin   = g_stage[k-1].valid_q;
            assign sum_d = {slice[CHUNK-1:0], g_stage[k-1].sum_q};
        end

        assign slice = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, cin};

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= vin;
                carry_q <= slice[CHUNK];
                sum_q   <= sum_d;
            end
        end

        // Upper operand slices travel with the partial sum; the last slice needs none.
        if (k < STAGES - 1) begin : g_ops
            logic [IW-CHUNK-1:0] a_q;
            logic [IW-CHUNK-1:0] b_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= op_a[IW-1:CHUNK];
                    b_q <= op_b[IW-1:CHUNK];
                end
            end
        end

`ifdef PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic msb_carry;
            logic ovf_q;

            // Carry into the MSB recovered from the MSB's own sum bit.
            assign msb_carry = op_a[IW-1] ^ op_b[IW-1] ^ slice[CHUNK-1];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= msb_carry ^ slice[CHUNK];
                end
            end
        end
`endif
    end

    assign last_valid = g_stage[STAGES-1].valid_q;
    assign out_valid  = last_valid;
    assign sum        = g_stage[STAGES-1].sum_q;
    assign c_out      = g_stage[STAGES-1].carry_q;
`ifdef PIPE_OVF_EN
    assign ovf        = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed-vector bench for pipelined_adder (WIDTH=16, STAGES=4); ovf checked when PIPE_OVF_EN is defined.
module tb_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
    localparam int EW     = WIDTH + 2;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } vec_t;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef PIPE_OVF_EN
    logic             ovf;
`endif

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc++;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            acc_cyc_q[$];
    logic [EW-1:0] cur_exp;
    logic [EW-1:0] mon_exp;
    int            mon_acc;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          chk_lat  = 1'b1;
    int            run_len  = 0;
    int            max_run  = 0;
    int            out_seen = 0;
    vec_t          vecs[12];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                                input logic vs, input logic [15:0] es, input logic ec, input logic eo);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vc; v.sub = vs; v.s = es; v.c = ec; v.o = eo;
        return v;
    endfunction

    // Transfers are decided by values stable at the falling edge; inputs only change 1ns after a rising edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid) begin
                out_seen++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("out_unexpected", {31'd0, out_valid}, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_acc = acc_cyc_q.pop_front();
                    check_val("sum", {16'd0, sum}, {16'd0, mon_exp[WIDTH-1:0]});
                    check_val("c_out", {31'd0, c_out}, {31'd0, mon_exp[WIDTH]});
`ifdef PIPE_OVF_EN
                    check_val("ovf", {31'd0, ovf}, {31'd0, mon_exp[WIDTH+1]});
`endif
                    if (chk_lat) check_val("latency_out", cyc - mon_acc, STAGES);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                acc_cyc_q.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_inputs(input vec_t v);
        a        = v.a;
        b        = v.b;
        c_in     = v.cin;
        sub      = v.sub;
        cur_exp  = {v.o, v.c, v.s};
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) check_val("accept_timeout", {31'd0, in_ready}, 32'd1);
        next_cycle();
    endtask

    task automatic send(input vec_t v);
        drive_inputs(v);
        wait_accept();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) check_val("drain_timeout", exp_q.size(), 32'd0);
        next_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        vecs[0]  = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        vecs[1]  = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        vecs[2]  = mk(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        vecs[3]  = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        vecs[4]  = mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        vecs[5]  = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        vecs[6]  = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        vecs[7]  = mk(16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        vecs[8]  = mk(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        vecs[9]  = mk(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        vecs[10] = mk(16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0);
        vecs[11] = mk(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0; cur_exp = '0;

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_sum", {16'd0, sum}, 32'd0);
        check_val("rst_c_out", {31'd0, c_out}, 32'd0);
`ifdef PIPE_OVF_EN
        check_val("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single operation latency
        next_cycle();
        drive_inputs(vecs[0]);
        @(negedge clock);
        next_cycle();
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!out_valid && lat < 20);
        check_val("latency_single", lat, STAGES);
        wait_drain();

        // Back-to-back stream of all vectors
        max_run = 0;
        for (int i = 0; i < 12; i++) send(vecs[i]);
        in_valid = 1'b0;
        wait_drain();
        check_val("b2b_run", max_run, 12);

        // Fill the pipe, then stall three cycles with a fifth operand waiting
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        for (int i = 3; i < 7; i++) send(vecs[i]);
        drive_inputs(vecs[7]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check_val("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check_val("stall_sum", {16'd0, sum}, 32'h8000);
            check_val("stall_c_out", {31'd0, c_out}, 32'd0);
        end
        next_cycle();
        out_ready = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        wait_drain();

        // Reset with three operations in flight
        out_ready = 1'b0;
        for (int i = 9; i < 12; i++) send(vecs[i]);
        in_valid = 1'b0;
        next_cycle();
        @(negedge clock);
        check_val("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check_val("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("midrst_sum", {16'd0, sum}, 32'd0);
        check_val("midrst_c_out", {31'd0, c_out}, 32'd0);
        exp_q.delete();
        acc_cyc_q.delete();
        next_cycle();
        reset     = 1'b0;
        out_ready = 1'b1;
        out_seen  = 0;
        repeat (8) @(negedge clock);
        check_val("post_rst_quiet", out_seen, 0);

        // Fresh operation after reset
        next_cycle();
        chk_lat = 1'b1;
        send(vecs[1]);
        in_valid = 1'b0;
        wait_drain();
        check_val("post_rst_count", out_seen, 1);
        check_val("final_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
